nbody_step_sched: RTL and testbench
===================================

Name: nbody_step_sched

Overview:
Central sequencer for one or more n-body integration steps. It issues (i,j) body-pair addresses into the fixed-latency acceleration pipeline and tracks each pair through it with a valid/tag shift register. It then runs the position-update sweep over the position adders and counts steps until the requested number is complete. It replaces the ad-hoc state/timer logic in the top-level wrapper. The top-level wrapper owns the RAMs and arithmetic and drives this block's start/ack from its bus registers.

Parameters:
BODIES, 512, maximum body count; RAM depth
IDX_W, $clog2(BODIES), body index width
PIPE_LAT, 123, cycles from pair address issue to acceleration-valid at the pipeline output (includes 1-cycle RAM read)
ADD_LAT, 20, AddSub latency in cycles
STEP_W, 16, step counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  single-cycle pulse; honoured only in IDLE
abort  in  1  synchronous abort; any state to IDLE
num_bodies  in  IDX_W+1  body count N, sampled at start
num_steps  in  STEP_W  steps to run, sampled at start; 0 is treated as 1
done_ack  in  1  software acknowledge of done
pair_i  out  IDX_W  issued body i (position/mass port A address)
pair_j  out  IDX_W  issued body j (position port B address)
acc_vld  out  1  acceleration result valid at pipeline output
acc_i  out  IDX_W  i tag aligned with acc_vld
acc_first  out  1  first pair of row i (clear accumulator)
acc_last  out  1  last pair of row i (commit velocity)
pos_rd_addr  out  IDX_W  position/velocity read address in update sweep
pos_wr_addr  out  IDX_W  position write address
pos_wren  out  1  position write enable
step_cnt  out  STEP_W  completed steps in the current run
busy  out  1  high in every state except IDLE and DONE
done  out  1  run complete, held until done_ack

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, including pipeline valids and step_cnt.
- States: IDLE, ACC_ISSUE, ACC_DRAIN, POS_SWEEP, POS_DRAIN, DONE.
- IDLE:
  - On start with N>=2: latch N and num_steps, set i=j=0, step_cnt=0, go to ACC_ISSUE.
  - On start with N<2: go directly to DONE, step_cnt=0.
- ACC_ISSUE: one pair per cycle.
  - pair_i/pair_j are registered and the tag is pushed on the same cycle.
  - j increments; when j==N-1 it wraps to 0 and i increments.
  - After issuing (N-1,N-1), go to ACC_DRAIN. No bubbles occur. N*N issue cycles.
- Tag pipeline: PIPE_LAT-deep register of {vld,i,first(j==0),last(j==N-1)}. A pair issued at cycle t appears on acc_* at t+PIPE_LAT exactly.
- ACC_DRAIN: remain until the last tag has exited and a further ADD_LAT+1 cycles have passed (velocity accumulate/write settle), then go to POS_SWEEP with rd=0.
- POS_SWEEP:
  - pos_rd_addr counts 0..N-1, one per cycle.
  - pos_wren/pos_wr_addr are the read address delayed by ADD_LAT+1 (1 RAM read plus the adder).
  - After rd=N-1, go to POS_DRAIN.
- POS_DRAIN: wait until the write with address N-1 has been issued, then on the next cycle increment step_cnt.
  - If step_cnt+1 == num_steps, go to DONE.
  - Otherwise go to ACC_ISSUE with i=j=0.
- DONE: done=1 and busy=0.
  - done_ack returns to IDLE with done cleared on the following cycle.
  - start while in DONE is ignored.
- abort:
  - Highest priority: on the next cycle the state is IDLE, every tag valid is cleared, pos_wren=0 and done=0.
  - step_cnt keeps its value.
- start while busy is ignored. Simultaneous start and abort in IDLE results in IDLE.
- All index arithmetic is modulo 2^IDX_W. N=BODIES must work, so N is compared at IDX_W+1 bits.

Optional Feature:
SKIP_SELF_EN:
- Defined: pairs with i==j are never issued. j steps over i, giving N*(N-1) issue cycles per step.
  - acc_first marks the first issued j of the row (j=1 when i=0).
  - acc_last marks the final issued j of the row (N-2 when i=N-1).
- Undefined: all N*N pairs are issued, and the downstream getAccl zero-distance guard handles self-pairs.

Test Plan:
1. Timing with PIPE_LAT=5, ADD_LAT=3, N=4, steps=1, SKIP_SELF_EN undefined; start at cycle 0 -> 16 issue cycles; acc_vld high for exactly 16 consecutive cycles starting 5 cycles after the first issue; acc_first on j=0 and acc_last on j=3 for each i; pos_wren high 4 cycles with addresses 0,1,2,3; done asserted, step_cnt=1.
2. Same setup with steps=3 -> three full ACC/POS phases; step_cnt steps 1,2,3; done only after the third; done held 10 cycles without ack, then clears 1 cycle after done_ack.
3. SKIP_SELF_EN defined, N=3 -> issue order (0,1)(0,2)(1,0)(1,2)(2,0)(2,1); acc_last on (0,2),(1,2),(2,1).
4. Abort mid-ACC_ISSUE at the 7th pair -> next cycle IDLE; acc_vld stays 0 afterwards; pos_wren never asserted; step_cnt unchanged.
5. N=1 start -> DONE next cycle; no acc_vld or pos_wren; step_cnt=0. Also: async reset asserted mid-POS_SWEEP -> all outputs 0 immediately.
6. N=BODIES=512 (PIPE_LAT default) -> 262144 issue cycles; i/j wrap correctly; final pos_wr_addr=511.

Source files
------------

// File: rtl/nbody_step_sched_if.sv
// Control/status bundle between the n-body top-level wrapper and nbody_step_sched.
// Port names are seen from the sequencer: _i driven by the wrapper, _o driven by the sequencer.
interface nbody_step_sched_if #(
  parameter int IDX_W  = 9,
  parameter int STEP_W = 16
);
  logic              start_i;
  logic              abort_i;
  logic [IDX_W:0]    num_bodies_i;
  logic [STEP_W-1:0] num_steps_i;
  logic              done_ack_i;
  logic [IDX_W-1:0]  pair_i_o;
  logic [IDX_W-1:0]  pair_j_o;
  logic              acc_vld_o;
  logic [IDX_W-1:0]  acc_i_o;
  logic              acc_first_o;
  logic              acc_last_o;
  logic [IDX_W-1:0]  pos_rd_addr_o;
  logic [IDX_W-1:0]  pos_wr_addr_o;
  logic              pos_wren_o;
  logic [STEP_W-1:0] step_cnt_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, abort_i, num_bodies_i, num_steps_i, done_ack_i,
    input  pair_i_o, pair_j_o, acc_vld_o, acc_i_o, acc_first_o, acc_last_o,
           pos_rd_addr_o, pos_wr_addr_o, pos_wren_o, step_cnt_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, num_bodies_i, num_steps_i, done_ack_i,
    output pair_i_o, pair_j_o, acc_vld_o, acc_i_o, acc_first_o, acc_last_o,
           pos_rd_addr_o, pos_wr_addr_o, pos_wren_o, step_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/nbody_step_sched.sv
// N-body step sequencer: pair issue with tag pipeline, position sweep, step counting.
// Define SKIP_SELF_EN to suppress i==j pairs (N*(N-1) issues per step instead of N*N).
module nbody_step_sched #(
  parameter int BODIES   = 512,
  parameter int IDX_W    = $clog2(BODIES),
  parameter int PIPE_LAT = 123,
  parameter int ADD_LAT  = 20,
  parameter int STEP_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  nbody_step_sched_if.slave bus
);
  localparam int DRAIN_CYC = PIPE_LAT + ADD_LAT + 1;
  localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC);
  localparam int TAG_W     = IDX_W + 3;

  typedef enum logic [2:0] {
    IDLE, ACC_ISSUE, ACC_DRAIN, POS_SWEEP, POS_DRAIN, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    n_q, n_d, n_m1, last_j;
  logic [STEP_W-1:0] steps_q, steps_d, step_q, step_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, j_next, first_j;
  logic [IDX_W-1:0]  pair_i_q, pair_i_d, pair_j_q, pair_j_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              issue, rd_vld, j_first, j_last, row_last, wr_hit;

  // Tag layout: {vld, first, last, i}; stage 0 is loaded together with pair_i/pair_j.
  logic [TAG_W-1:0]  tag_q [0:PIPE_LAT];
  logic [IDX_W:0]    wr_q  [0:ADD_LAT];

  assign n_m1 = n_q - 1'b1;

`ifdef SKIP_SELF_EN
  localparam logic [IDX_W-1:0] START_J = IDX_W'(1);
  assign first_j = (i_q == '0) ? IDX_W'(1) : '0;
  assign last_j  = ({1'b0, i_q} == n_m1) ? n_q - (IDX_W+1)'(2) : n_m1;
  assign j_next  = (j_q + 1'b1 == i_q) ? j_q + IDX_W'(2) : j_q + 1'b1;
`else
  localparam logic [IDX_W-1:0] START_J = '0;
  assign first_j = '0;
  assign last_j  = n_m1;
  assign j_next  = j_q + 1'b1;
`endif

  assign j_first  = (j_q == first_j);
  assign j_last   = ({1'b0, j_q} == last_j);
  assign row_last = ({1'b0, i_q} == n_m1);
  assign wr_hit   = wr_q[ADD_LAT][IDX_W] && ({1'b0, wr_q[ADD_LAT][IDX_W-1:0]} == n_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      steps_q  <= '0;
      step_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      pair_i_q <= '0;
      pair_j_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      steps_q  <= steps_d;
      step_q   <= step_d;
      i_q      <= i_d;
      j_q      <= j_d;
      pair_i_q <= pair_i_d;
      pair_j_q <= pair_j_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    steps_d  = steps_q;
    step_d   = step_q;
    i_d      = i_q;
    j_d      = j_q;
    pair_i_d = pair_i_q;
    pair_j_d = pair_j_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    issue    = 1'b0;
    rd_vld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          step_d = '0;
          if (bus.num_bodies_i >= (IDX_W+1)'(2)) begin
            n_d     = bus.num_bodies_i;
            steps_d = (bus.num_steps_i == '0) ? STEP_W'(1) : bus.num_steps_i;
            i_d     = '0;
            j_d     = START_J;
            state_d = ACC_ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC_ISSUE: begin
        issue    = 1'b1;
        pair_i_d = i_q;
        pair_j_d = j_q;
        if (j_last) begin
          if (row_last) begin
            state_d = ACC_DRAIN;
            cnt_d   = '0;
          end else begin
            i_d = i_q + 1'b1;
            j_d = '0;
          end
        end else begin
          j_d = j_next;
        end
      end
      // Covers the last tag leaving the pipe plus the velocity add/write settle time.
      ACC_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = POS_SWEEP;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      POS_SWEEP: begin
        rd_vld = 1'b1;
        if ({1'b0, rd_q} == n_m1) state_d = POS_DRAIN;
        else                      rd_d    = rd_q + 1'b1;
      end
      POS_DRAIN: begin
        if (wr_hit) begin
          step_d = step_q + 1'b1;
          if (step_d == steps_q) begin
            state_d = DONE;
          end else begin
            state_d = ACC_ISSUE;
            i_d     = '0;
            j_d     = START_J;
          end
        end
      end
      DONE: begin
        if (bus.done_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) begin
      state_d = IDLE;
      step_d  = step_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q[0] <= '0;
      wr_q[0]  <= '0;
    end else begin
      tag_q[0] <= {issue & ~bus.abort_i, j_first, j_last, i_q};
      wr_q[0]  <= {rd_vld & ~bus.abort_i, rd_q};
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= PIPE_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           tag_q[gi] <= '0;
        else if (bus.abort_i) tag_q[gi] <= {1'b0, tag_q[gi-1][TAG_W-2:0]};
        else                  tag_q[gi] <= tag_q[gi-1];
      end
    end
    for (gi = 1; gi <= ADD_LAT; gi++) begin : g_wr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           wr_q[gi] <= '0;
        else if (bus.abort_i) wr_q[gi] <= {1'b0, wr_q[gi-1][IDX_W-1:0]};
        else                  wr_q[gi] <= wr_q[gi-1];
      end
    end
  endgenerate

  assign bus.pair_i_o      = pair_i_q;
  assign bus.pair_j_o      = pair_j_q;
  assign bus.acc_vld_o     = tag_q[PIPE_LAT][TAG_W-1];
  assign bus.acc_first_o   = tag_q[PIPE_LAT][TAG_W-2];
  assign bus.acc_last_o    = tag_q[PIPE_LAT][TAG_W-3];
  assign bus.acc_i_o       = tag_q[PIPE_LAT][IDX_W-1:0];
  assign bus.pos_rd_addr_o = rd_q;
  assign bus.pos_wr_addr_o = wr_q[ADD_LAT][IDX_W-1:0];
  assign bus.pos_wren_o    = wr_q[ADD_LAT][IDX_W];
  assign bus.step_cnt_o    = step_q;
  assign bus.busy_o        = (state_q != IDLE) && (state_q != DONE);
  assign bus.done_o        = (state_q == DONE);
endmodule

// File: tb/tb_nbody_step_sched.sv
// Directed bench for nbody_step_sched with short latencies (PIPE_LAT=5, ADD_LAT=3, BODIES=16).
// Cycle c counts sampling negedges after the edge that accepts start (c=1 is the first ACC_ISSUE cycle).
module tb_nbody_step_sched;
  localparam int BODIES   = 16;
  localparam int IDX_W    = 4;
  localparam int PIPE_LAT = 5;
  localparam int ADD_LAT  = 3;
  localparam int STEP_W   = 16;
  localparam int OW       = 5*IDX_W + STEP_W + 6;
`ifdef SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  nbody_step_sched_if #(.IDX_W(IDX_W), .STEP_W(STEP_W)) bus ();

  nbody_step_sched #(
    .BODIES(BODIES), .IDX_W(IDX_W), .PIPE_LAT(PIPE_LAT), .ADD_LAT(ADD_LAT), .STEP_W(STEP_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] all_o;
  assign all_o = {bus.pair_i_o, bus.pair_j_o, bus.acc_vld_o, bus.acc_i_o, bus.acc_first_o,
                  bus.acc_last_o, bus.pos_rd_addr_o, bus.pos_wr_addr_o, bus.pos_wren_o,
                  bus.step_cnt_o, bus.busy_o, bus.done_o};

  // Observations gathered by watch()
  int cyc, acc_cnt, acc_first_c, acc_last_c, acc_bad, last_flags, pair_bad;
  int wr_cnt, wr_first_c, wr_last_addr, wr_bad, done_c;
  int step_at [0:3];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic int iss(input int n);
    return SKIP ? n*(n-1) : n*n;
  endfunction

  // k-th issued pair of a step for body count n
  task automatic pair_of(input int n, input int k, output int pi, output int pj,
                         output bit pf, output bit pl);
    int r;
    if (SKIP) begin
      pi = k / (n-1);
      r  = k % (n-1);
      pj = (r < pi) ? r : r + 1;
      pf = (r == 0);
      pl = (r == n-2);
    end else begin
      pi = k / n;
      pj = k % n;
      pf = (pj == 0);
      pl = (pj == n-1);
    end
  endtask

  task automatic start_cmd(input int n, input int s);
    bus.num_bodies_i = (IDX_W+1)'(n);
    bus.num_steps_i  = STEP_W'(s);
    bus.start_i      = 1'b1;
  endtask

  task automatic watch(input int n, input int maxc);
    int pi, pj, is, prev;
    bit pf, pl;
    is = iss(n);
    cyc = 0; acc_cnt = 0; acc_first_c = -1; acc_last_c = -1; acc_bad = 0;
    last_flags = 0; pair_bad = 0; wr_cnt = 0; wr_first_c = -1; wr_last_addr = -1;
    wr_bad = 0; done_c = -1; prev = 0;
    for (int k = 0; k < 4; k++) step_at[k] = -1;
    while (cyc < maxc) begin
      @(negedge clk);
      cyc++;
      bus.start_i = 1'b0;
      if (cyc >= 2 && cyc <= is + 1) begin
        pair_of(n, cyc - 2, pi, pj, pf, pl);
        if (int'(bus.pair_i_o) != pi || int'(bus.pair_j_o) != pj) pair_bad++;
      end
      if (bus.acc_vld_o) begin
        pair_of(n, acc_cnt % is, pi, pj, pf, pl);
        if (acc_cnt == 0) acc_first_c = cyc;
        acc_last_c = cyc;
        if (int'(bus.acc_i_o) != pi || bus.acc_first_o != pf || bus.acc_last_o != pl) acc_bad++;
        if (bus.acc_last_o) last_flags++;
        acc_cnt++;
      end
      if (bus.pos_wren_o) begin
        if (wr_cnt == 0) wr_first_c = cyc;
        if (int'(bus.pos_wr_addr_o) != wr_cnt % n) wr_bad++;
        wr_last_addr = int'(bus.pos_wr_addr_o);
        wr_cnt++;
      end
      if (int'(bus.step_cnt_o) != prev) begin
        prev = int'(bus.step_cnt_o);
        if (prev >= 1 && prev <= 3) step_at[prev] = cyc;
      end
      if (bus.done_o) begin
        done_c = cyc;
        break;
      end
    end
  endtask

  task automatic ack_done(input string tag);
    bus.done_ack_i = 1'b1;
    @(negedge clk);
    bus.done_ack_i = 1'b0;
    chk(tag, int'(bus.done_o), 0);
  endtask

  initial begin
    int is4, is3, is16, pi, pj, n_seen_acc, n_seen_wr, n_seen_done, n_seen_busy;
    bit pf, pl;
    is4  = iss(4);
    is3  = iss(3);
    is16 = iss(16);
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.done_ack_i = 1'b0;
    bus.num_bodies_i = '0; bus.num_steps_i = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", $countones(all_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset: outputs idle");

    // 1: N=4, one step
    start_cmd(4, 1);
    watch(4, 200);
    chk("t1_acc_first_cycle", acc_first_c, 7);
    chk("t1_acc_count", acc_cnt, is4);
    chk("t1_acc_last_cycle", acc_last_c, 6 + is4);
    chk("t1_acc_tags", acc_bad, 0);
    chk("t1_pair_order", pair_bad, 0);
    chk("t1_acc_last_flags", last_flags, 4);
    chk("t1_wr_first_cycle", wr_first_c, is4 + 15);
    chk("t1_wr_count", wr_cnt, 4);
    chk("t1_wr_addrs", wr_bad, 0);
    chk("t1_done_cycle", done_c, is4 + 19);
    chk("t1_step_cnt", int'(bus.step_cnt_o), 1);
    chk("t1_busy_in_done", int'(bus.busy_o), 0);
    $display("txn t1: N=4 steps=1 done at c=%0d", done_c);
    ack_done("t1_done_cleared");

    // 2: N=4, three steps, done held without ack, start ignored in DONE
    start_cmd(4, 3);
    watch(4, 400);
    chk("t2_step1_cycle", step_at[1], 1 + (is4 + 18));
    chk("t2_step2_cycle", step_at[2], 1 + 2*(is4 + 18));
    chk("t2_done_cycle", done_c, 1 + 3*(is4 + 18));
    chk("t2_step_cnt", int'(bus.step_cnt_o), 3);
    chk("t2_acc_count", acc_cnt, 3*is4);
    chk("t2_acc_tags", acc_bad, 0);
    chk("t2_wr_count", wr_cnt, 12);
    chk("t2_wr_addrs", wr_bad, 0);
    start_cmd(4, 1);
    n_seen_done = 0; n_seen_busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) n_seen_done++;
      if (bus.busy_o) n_seen_busy++;
    end
    chk("t2_done_held", n_seen_done, 10);
    chk("t2_start_in_done_ignored", n_seen_busy, 0);
    ack_done("t2_done_cleared");
    chk("t2_idle_after_ack", int'(bus.busy_o), 0);
    $display("txn t2: N=4 steps=3 done at c=%0d", done_c);

    // 3: N=3 ordering and row flags
    start_cmd(3, 1);
    watch(3, 200);
    chk("t3_acc_count", acc_cnt, is3);
    chk("t3_pair_order", pair_bad, 0);
    chk("t3_acc_tags", acc_bad, 0);
    chk("t3_acc_last_flags", last_flags, 3);
    chk("t3_done_cycle", done_c, is3 + 18);
    $display("txn t3: N=3 issues=%0d", acc_cnt);
    ack_done("t3_done_cleared");

    // 4: abort at the 7th issued pair
    start_cmd(4, 1);
    repeat (8) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    pair_of(4, 6, pi, pj, pf, pl);
    chk("t4_pair7_i", int'(bus.pair_i_o), pi);
    chk("t4_pair7_j", int'(bus.pair_j_o), pj);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("t4_idle_after_abort", int'(bus.busy_o), 0);
    n_seen_acc = 0; n_seen_wr = 0; n_seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.acc_vld_o) n_seen_acc++;
      if (bus.pos_wren_o) n_seen_wr++;
      if (bus.done_o) n_seen_done++;
      @(negedge clk);
    end
    chk("t4_no_acc_vld", n_seen_acc, 0);
    chk("t4_no_pos_wren", n_seen_wr, 0);
    chk("t4_no_done", n_seen_done, 0);
    chk("t4_step_cnt", int'(bus.step_cnt_o), 0);
    $display("txn t4: abort at pair 7");

    // 4b: abort after the first of three steps keeps step_cnt
    start_cmd(4, 3);
    watch(4, is4 + 19);
    chk("t4b_step_before_abort", int'(bus.step_cnt_o), 1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("t4b_step_kept", int'(bus.step_cnt_o), 1);
    chk("t4b_idle", int'(bus.busy_o), 0);
    n_seen_wr = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.pos_wren_o) n_seen_wr++;
    end
    chk("t4b_no_pos_wren", n_seen_wr, 0);

    // start and abort together in IDLE
    start_cmd(4, 1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("t4c_start_abort_idle", int'(bus.busy_o) + int'(bus.done_o), 0);
    $display("txn t4b: abort keeps step_cnt");

    // 5: N=1 goes straight to DONE
    start_cmd(1, 1);
    watch(1, 10);
    chk("t5_done_cycle", done_c, 1);
    chk("t5_no_acc", acc_cnt, 0);
    chk("t5_no_wr", wr_cnt, 0);
    chk("t5_step_cnt", int'(bus.step_cnt_o), 0);
    ack_done("t5_done_cleared");
    $display("txn t5: N=1 done immediately");

    // 5b: asynchronous reset in the middle of POS_SWEEP
    start_cmd(4, 1);
    repeat (is4 + 12) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    chk("t5b_rd_addr_in_sweep", int'(bus.pos_rd_addr_o), 1);
    chk("t5b_busy_in_sweep", int'(bus.busy_o), 1);
    #2 rst_n = 1'b0;
    #1 chk("t5b_async_reset_zero", $countones(all_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5b_idle_after_reset", int'(bus.busy_o) + int'(bus.done_o), 0);
    $display("txn t5b: async reset mid sweep");

    // 6: maximum body count for this build
    start_cmd(BODIES, 1);
    watch(BODIES, 600);
    chk("t6_acc_count", acc_cnt, is16);
    chk("t6_pair_order", pair_bad, 0);
    chk("t6_acc_tags", acc_bad, 0);
    chk("t6_wr_count", wr_cnt, BODIES);
    chk("t6_final_wr_addr", wr_last_addr, BODIES - 1);
    chk("t6_done_cycle", done_c, is16 + 15 + BODIES);
    ack_done("t6_done_cleared");
    $display("txn t6: N=%0d done at c=%0d", BODIES, done_c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
